// File: rtl/uart_tx.sv
// uart_tx -- byte-to-serial UART transmitter.
//
// Accepts bytes on a valid/ready handshake and shifts them out as
// 8N1 / 8N2 frames (start bit, 8 data bits LSB first, optional even
// parity, 1 or 2 stop bits). Each bit lasts CYCLES_PER_BIT clocks.
// The byte is captured on the handshake, so tx_data may change freely
// while a frame is in flight.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity
// bit after data bit 7.
//
// Parameters:
//   CYCLES_PER_BIT  clocks per serial bit (>= 2), default 868
//   STOP_BITS       number of stop bits (1 or 2), default 1
// Ports:
//   clk        system clock
//   m_aresetn  asynchronous active-low reset
//   tx_valid   upstream byte valid
//   tx_data    upstream byte, sampled on the handshake only
//   tx_ready   block can accept a byte (registered)
//   uart_txd   serial line, idle high (registered)
//   busy       frame in progress, always !tx_ready (registered)

module uart_tx #(
  parameter int unsigned CYCLES_PER_BIT = 868,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic       clk,
  input  logic       m_aresetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       busy
);

  localparam int unsigned TW = $clog2(CYCLES_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CYCLES_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          stop_q, stop_d;
  logic          ready_q, ready_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic bit_end;
  logic stop_done;

  assign bit_end = (timer_q == T_LAST);
  // With a single stop bit the first stop-bit boundary ends the frame;
  // with two, stop_q marks that the first one has already elapsed.
  assign stop_done = (STOP_BITS < 2) || stop_q;

  always_comb begin
    state_d = state_q;
    timer_d = bit_end ? '0 : timer_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    stop_d  = stop_q;
    ready_d = ready_q;
    txd_d   = txd_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // uart_txd is registered, so each branch loads the value of the
    // *next* bit at the boundary edge; the line changes exactly on it.
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (tx_valid && ready_q) begin
          shreg_d = tx_data;
          idx_d   = '0;
          stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
          state_d = S_START;
          txd_d   = 1'b0;
          ready_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          txd_d   = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = par_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          if (stop_done) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        ready_d = 1'b1;
        txd_d   = 1'b1;
      end
    endcase

    busy_d = ~ready_d;
  end

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      stop_q  <= 1'b0;
      ready_q <= 1'b1;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      stop_q  <= stop_d;
      ready_q <= ready_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_ready = ready_q;
  assign uart_txd = txd_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed testbench for uart_tx with CYCLES_PER_BIT=4,
// STOP_BITS=1. Frame expectations are written out as bit patterns
// {stop, d7..d0, start}; the parity bit is spliced in when the design
// is built with UART_TX_PARITY_EN.

module tb_uart_tx;

  localparam int unsigned C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned F = (9 + P + 1) * C;

  logic       clk = 1'b0;
  logic       m_aresetn = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       uart_txd;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int k_cyc = 0;

  uart_tx #(.CYCLES_PER_BIT(C), .STOP_BITS(1)) dut (
    .clk       (clk),
    .m_aresetn (m_aresetn),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .uart_txd  (uart_txd),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // {stop, d7..d0, start}
    logic       par;     // even parity of data
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for tx_ready, present a byte and step through the
  // accepting edge. Returns #1 after that edge.
  task automatic accept(input logic [7:0] d);
    for (int i = 0; i < 200 && tx_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    chk("ready_before_accept", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    k_cyc = cyc;
  endtask

  // Called #1 after the accepting edge k. Samples every cycle of the
  // frame, then steps to edge k+F and checks the block is idle again.
  task automatic check_frame(input string nm, input logic [9:0] fr, input logic par,
                             input bit drop_valid);
    logic [10:0] expw;
    logic [10:0] obs;
    int unsigned slot;
    int unsigned low;
    int unsigned unstable;
    int unsigned busy_bad;
    if (drop_valid) tx_valid = 1'b0;
    expw = (P != 0) ? {1'b1, par, fr[8:0]} : {1'b0, fr};
    obs = '0;
    low = 0;
    unstable = 0;
    busy_bad = 0;
    for (int unsigned i = 0; i < F; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      slot = i / C;
      if (i % C == 0) obs[slot] = uart_txd;
      else if (uart_txd !== obs[slot]) unstable++;
      if (tx_ready === 1'b0) low++;
      if (busy !== ~tx_ready) busy_bad++;
    end
    chk($sformatf("%s frame_bits", nm), {21'd0, obs}, {21'd0, expw});
    chk($sformatf("%s bit_stability", nm), unstable, 0);
    chk($sformatf("%s ready_low_cycles", nm), low, F);
    chk($sformatf("%s busy_vs_ready", nm), busy_bad, 0);
    @(posedge clk); #1;
    chk($sformatf("%s ready_after", nm), {31'd0, tx_ready}, 32'd1);
    chk($sformatf("%s txd_after", nm), {31'd0, uart_txd}, 32'd1);
  endtask

  initial begin
    int rst_bad;
    int k1;

    vecs[0] = '{8'h55, 10'b1_01010101_0, 1'b0};
    vecs[1] = '{8'h07, 10'b1_00000111_0, 1'b1};
    vecs[2] = '{8'h03, 10'b1_00000011_0, 1'b0};
    vecs[3] = '{8'hC1, 10'b1_11000001_0, 1'b1};

    // Reset held for 5 cycles with tx_valid asserted.
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    rst_bad  = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (uart_txd !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) rst_bad++;
    end
    chk("reset_outputs", rst_bad, 0);
    tx_valid  = 1'b0;
    m_aresetn = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_no_frame", {29'd0, uart_txd, tx_ready, busy}, 32'b110);

    // Table-driven single frames.
    foreach (vecs[i]) begin
      accept(vecs[i].data);
      check_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].par, 1'b1);
    end

    // Back-to-back with tx_valid held: 0xA3 then 0x0F.
    accept(8'hA3);
    k1 = k_cyc;
    tx_data = 8'h0F;
    check_frame("b2b_first", 10'b1_10100011_0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("b2b_second_start", {31'd0, uart_txd}, 32'd0);
    chk("b2b_period", cyc - k1, F + 1);
    check_frame("b2b_second", 10'b1_00001111_0, 1'b0, 1'b1);

    // Data stability: 0x00 accepted, 0xFF presented throughout.
    accept(8'h00);
    tx_data = 8'hFF;
    check_frame("stab_zero", 10'b1_00000000_0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("stab_next_accept", {31'd0, uart_txd}, 32'd0);
    check_frame("stab_ff", 10'b1_11111111_0, 1'b0, 1'b1);

    // Reset in the middle of a 0x3C frame, away from any clock edge.
    accept(8'h3C);
    tx_valid = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    chk("midframe_pre_txd", {31'd0, tx_ready}, 32'd0);
    #1 m_aresetn = 1'b0;
    #1;
    chk("midframe_abort", {29'd0, uart_txd, tx_ready, busy}, 32'b110);
    @(posedge clk); #1;
    m_aresetn = 1'b1;
    @(posedge clk); #1;
    chk("midframe_idle", {29'd0, uart_txd, tx_ready, busy}, 32'b110);
    accept(8'h81);
    check_frame("after_abort", 10'b1_10000001_0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-to-serial UART transmitter that sits directly downstream of `uartprobe`: it consumes the probe's `tx_valid`/`tx_data`/`tx_ready` byte stream and drives the physical UART TX pin. Frames are 8 data bits, LSB first, with optional even parity and 1 or 2 stop bits. The bit rate is set by a fixed clocks-per-bit divisor. Each accepted byte is captured into a shift register, so the upstream side may change `tx_data` immediately after the handshake.

## Interface
- `CYCLES_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal range ≥ 2.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

- `clk`  in  1  system clock.
- `m_aresetn`  in  1  one clock; reset is asynchronous and active-low.
- `tx_valid`  in  1  upstream byte valid.
- `tx_data`  in  8  upstream byte; sampled only on handshake.
- `tx_ready`  out  1  block can accept a byte; registered.
- `uart_txd`  out  1  serial line, idle high (mark); registered.
- `busy`  out  1  frame in progress; registered, equals `!tx_ready`.

## Operation
- The FSM has states IDLE, START, DATA, PARITY and STOP. PARITY exists only when the parity feature is compiled in.
- IDLE:
  - `tx_ready=1`, `uart_txd=1`.
  - On an edge with `tx_valid && tx_ready`, capture `tx_data` into the shift register, clear the bit timer and bit index, and go to START.
- START: drive `uart_txd=0` for `CYCLES_PER_BIT` cycles, then go to DATA.
- DATA:
  - Drive shift register bit 0, one bit per `CYCLES_PER_BIT` cycles, shifting right after each bit.
  - A 3-bit index counts 0..7. After bit 7 go to PARITY if enabled, else STOP.
- PARITY: drive the XOR of the captured 8 bits (even parity) for one bit time, then go to STOP.
- STOP:
  - Drive `uart_txd=1` for `STOP_BITS*CYCLES_PER_BIT` cycles.
  - When the final count completes, go to IDLE and assert `tx_ready`.
- Bit timer:
  - Width `$clog2(CYCLES_PER_BIT)`.
  - Counts 0..`CYCLES_PER_BIT-1`, wraps to 0 on each bit boundary, and never exceeds the terminal value.
- Outside IDLE, `tx_valid` is ignored and `tx_data` changes have no effect on the frame in flight.
- `tx_valid` deasserting mid-frame has no effect; the frame always completes.
- Reset mid-frame:
  - The frame is aborted immediately (asynchronously).
  - `uart_txd` returns to 1. The partial frame is discarded and not retransmitted.

## Timing
- Reset values: `uart_txd=1`, `tx_ready=1`, `busy=0`, FSM in IDLE, all counters 0.
- Handshake edge k: `uart_txd` falls and `tx_ready` falls at edge k, both visible in cycle k+1.
- Let F = (9 + P + `STOP_BITS`) × `CYCLES_PER_BIT`, where P = 1 with parity and 0 without.
- The frame occupies edges k..k+F. `tx_ready` rises at edge k+F.
- With `tx_valid` held high, the next accept is at edge k+F+1. The back-to-back frame period is therefore F+1 cycles, i.e. one extra idle-high cycle between frames.
- Bit n (0 = start) is stable on `uart_txd` for exactly `CYCLES_PER_BIT` cycles starting at edge k + n×`CYCLES_PER_BIT`.
- Latency from accept to start-bit edge: 0 cycles after the accepting edge.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - The PARITY state is present.
  - An even-parity bit is inserted after data bit 7.
  - F = (10 + `STOP_BITS`) × `CYCLES_PER_BIT`.
- Undefined:
  - The PARITY state and its logic are absent.
  - DATA goes directly to STOP.
  - F = (9 + `STOP_BITS`) × `CYCLES_PER_BIT`.

## Test plan
All scenarios use `CYCLES_PER_BIT=4` and `STOP_BITS=1`, with parity off unless stated.
- **Reset:** hold `m_aresetn=0` for 5 cycles with `tx_valid=1` → `uart_txd=1`, `tx_ready=1`, `busy=0`, and no frame starts until release.
- **Single byte:** send 0x55 → `uart_txd` shows 0 for 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles. `tx_ready` is low for exactly 40 cycles.
- **Back-to-back:** hold `tx_valid` with 0xA3 then 0x0F → the second start bit falls 41 cycles after the first. Decoded bytes are 0xA3 then 0x0F.
- **Data stability:** accept 0x00, then drive `tx_data=0xFF` and `tx_valid=1` throughout the frame → all 8 data bits are 0 and no second accept occurs until `tx_ready` returns.
- **Reset mid-frame:** assert reset at cycle 15 of a 0x3C frame → `uart_txd=1` with no clock edge needed. After release, 0x81 transmits correctly with a 40-cycle frame.
- **Parity (`UART_TX_PARITY_EN`):**
  - 0x07 → parity slot (bit 9) = 1, frame 44 cycles.
  - 0x03 → parity slot = 0.
  - Without the macro, the same bytes give a 40-cycle frame with the stop bit in slot 9.
